// File: rtl/seg7_scan_ctrl.sv
// Four-digit 7-segment scan controller: double-buffered digits,
// per-slot blanking dead-time, leading-zero suppression.
module seg7_scan_ctrl #(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bcd_in,
    input  logic [3:0]  dp_in,
    input  logic        lzb_en,
    input  logic        load,
    output logic [3:0]  sel,
    output logic [7:0]  dig,
    output logic        frame_done
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_DRV  = CW'(BLANK_CYC);

    logic [15:0]   r_st_bcd;
    logic [3:0]    r_st_dp;
    logic          r_pend;
    logic [15:0]   r_sh_bcd;
    logic [3:0]    r_sh_dp;
    logic [1:0]    r_slot;
    logic [CW-1:0] r_cnt;
    logic          r_run;
    logic [3:0]    r_sel;
    logic [7:0]    r_dig;
    logic          r_frame_done;

    logic [3:0]    w_digit [4];
    logic [3:0]    w_zero;
    logic [3:0]    w_lzb_mask;
    logic [3:0]    w_nib;
    logic          w_drive;
    logic          w_wrap;
    logic          w_boundary;
    logic [7:0]    w_seg;
    logic [3:0]    w_sel;
    logic [7:0]    w_dig;

    function automatic logic [7:0] seg_decode(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'd0:    seg = 8'hFC;
            4'd1:    seg = 8'h60;
            4'd2:    seg = 8'hDA;
            4'd3:    seg = 8'hF2;
            4'd4:    seg = 8'h66;
            4'd5:    seg = 8'hB6;
            4'd6:    seg = 8'hBE;
            4'd7:    seg = 8'hE0;
            4'd8:    seg = 8'hFE;
            4'd9:    seg = 8'hF6;
            default: seg = 8'h02;
        endcase
        return seg;
    endfunction

    // The internal count runs one edge ahead of the registered outputs,
    // so the first edge out of reset still shows count 0.
    always_comb begin
        w_wrap     = (r_cnt == CNT_LAST);
        w_drive    = (r_cnt >= CNT_DRV);
        w_boundary = r_run && (r_slot == 2'd0) && (r_cnt == '0);
    end

    always_comb begin
        w_digit[0] = r_sh_bcd[3:0];
        w_digit[1] = r_sh_bcd[7:4];
        w_digit[2] = r_sh_bcd[11:8];
        w_digit[3] = r_sh_bcd[15:12];
        for (int i = 0; i < 4; i++) begin
            w_zero[i] = (w_digit[i] == 4'd0);
        end
        w_lzb_mask[0] = 1'b0;
        w_lzb_mask[1] = lzb_en & w_zero[3] & w_zero[2] & w_zero[1];
        w_lzb_mask[2] = lzb_en & w_zero[3] & w_zero[2];
        w_lzb_mask[3] = lzb_en & w_zero[3];
        w_nib = w_digit[r_slot];
    end

    always_comb begin
        w_seg = seg_decode(w_nib);
        if (w_lzb_mask[r_slot]) begin
            w_seg[7:1] = 7'd0;
        end
        w_seg[0] = r_sh_dp[r_slot];
        w_sel = 4'b1111;
        w_dig = 8'h00;
        if (w_drive) begin
            w_sel[r_slot] = 1'b0;
            w_dig         = w_seg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot <= 2'd0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_wrap) begin
                r_cnt  <= '0;
                r_slot <= r_slot + 2'd1;
            end else begin
                r_cnt  <= r_cnt + 1'b1;
            end
        end
    end

    // A load on the boundary edge wins over the clear of pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_st_bcd <= 16'd0;
            r_st_dp  <= 4'd0;
            r_pend   <= 1'b0;
            r_sh_bcd <= 16'd0;
            r_sh_dp  <= 4'd0;
        end else begin
            if (w_boundary && r_pend) begin
                r_sh_bcd <= r_st_bcd;
                r_sh_dp  <= r_st_dp;
            end
            if (load) begin
                r_st_bcd <= bcd_in;
                r_st_dp  <= dp_in;
                r_pend   <= 1'b1;
            end else if (w_boundary) begin
                r_pend   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel        <= 4'b1111;
            r_dig        <= 8'h00;
            r_frame_done <= 1'b0;
        end else begin
            r_sel        <= w_sel;
            r_dig        <= w_dig;
            r_frame_done <= w_boundary;
        end
    end

    assign sel        = r_sel;
    assign dig        = r_dig;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl against a count-based model.
module tb_seg7_scan_ctrl;

    localparam int CD = 8;
    localparam int BC = 2;
    localparam int FR = 4 * CD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bcd_in = 16'd0;
    logic [3:0]  dp_in = 4'd0;
    logic        lzb_en = 1'b0;
    logic        load = 1'b0;
    logic [3:0]  sel;
    logic [7:0]  dig;
    logic        frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    int          m_n = -1;
    logic [15:0] m_st_bcd = 16'd0;
    logic [3:0]  m_st_dp = 4'd0;
    logic [15:0] m_sh_bcd = 16'd0;
    logic [3:0]  m_sh_dp = 4'd0;
    logic        m_pend = 1'b0;
    logic        m_lzb = 1'b0;

    logic [7:0] SEG [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                             8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

    seg7_scan_ctrl #(.CLK_DIV(CD), .BLANK_CYC(BC)) dut (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in),
        .lzb_en(lzb_en), .load(load), .sel(sel), .dig(dig),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        if (rst) begin
            m_n = -1;
            m_st_bcd = 16'd0;
            m_st_dp = 4'd0;
            m_sh_bcd = 16'd0;
            m_sh_dp = 4'd0;
            m_pend = 1'b0;
        end else begin
            m_n++;
            if (m_n > 0 && m_n % FR == 0 && m_pend) begin
                m_sh_bcd = m_st_bcd;
                m_sh_dp = m_st_dp;
                m_pend = 1'b0;
            end
            if (load) begin
                m_st_bcd = bcd_in;
                m_st_dp = dp_in;
                m_pend = 1'b1;
            end
        end
        m_lzb = lzb_en;
        #1;
    endtask

    function automatic logic [3:0] exp_sel();
        logic [3:0] one = 4'b0001;
        if (m_n < 0 || m_n % CD < BC) return 4'b1111;
        return ~(one << ((m_n / CD) % 4));
    endfunction

    function automatic logic [7:0] exp_dig();
        int s;
        logic [15:0] hi;
        logic [3:0] nib;
        logic [7:0] seg;
        if (m_n < 0 || m_n % CD < BC) return 8'h00;
        s = (m_n / CD) % 4;
        hi = m_sh_bcd >> (4 * s);
        nib = hi[3:0];
        seg = (nib < 4'd10) ? SEG[int'(nib)] : 8'h02;
        if (m_lzb && s > 0 && hi == 16'd0) seg = 8'h00;
        return seg | {7'd0, m_sh_dp[s]};
    endfunction

    function automatic logic exp_fd();
        return (m_n > 0 && m_n % FR == 0);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bcd_in = 16'($urandom);
            load = 1'($urandom);
            step();
            n_tests++;
            if ({sel, dig, frame_done} !== 13'b1111_0000_0000_0) begin
                n_fail++;
                $display("FAIL reset sel=%b dig=%h fd=%b want 1111/00/0",
                         sel, dig, frame_done);
            end
        end
        load = 1'b0;
    endtask

    task automatic test_scan();
        rst = 1'b0;
        lzb_en = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            n_tests++;
            if ({sel, dig, frame_done} !==
                {exp_sel(), exp_dig(), exp_fd()}) begin
                n_fail++;
                $display("FAIL scan n=%0d got %b/%h/%b exp %b/%h/%b",
                         m_n, sel, dig, frame_done,
                         exp_sel(), exp_dig(), exp_fd());
            end
            if (m_n == 1 || m_n == 2 || m_n == 26 || m_n == 32) begin
                n_tests++;
                if ((m_n == 1 && {sel, dig} !== 12'hF00) ||
                    (m_n == 2 && {sel, dig} !== 12'hEFC) ||
                    (m_n == 26 && {sel, dig} !== 12'h7FC) ||
                    (m_n == 32 && {sel, frame_done} !== 5'b11111)) begin
                    n_fail++;
                    $display("FAIL scan_fixed n=%0d got %b/%h/%b",
                             m_n, sel, dig, frame_done);
                end
            end
        end
    endtask

    task automatic test_load_midframe();
        int fb;
        while (m_n % FR != 11) step();
        bcd_in = 16'h1234;
        dp_in = 4'b0100;
        load = 1'b1;
        step();
        load = 1'b0;
        fb = (m_n / FR + 1) * FR;
        while (m_n < fb + FR - 1) begin
            step();
            n_tests++;
            if ({sel, dig, frame_done} !==
                {exp_sel(), exp_dig(), exp_fd()}) begin
                n_fail++;
                $display("FAIL load_mid n=%0d got %b/%h/%b exp %b/%h/%b",
                         m_n, sel, dig, frame_done,
                         exp_sel(), exp_dig(), exp_fd());
            end
            if (m_n < fb && m_n % CD >= BC) begin
                n_tests++;
                if (dig !== 8'hFC) begin
                    n_fail++;
                    $display("FAIL load_old n=%0d dig=%h want FC", m_n, dig);
                end
            end
            if (m_n >= fb && m_n % FR == 2 * CD + 3) begin
                n_tests++;
                if (sel !== 4'b1011 || dig !== 8'hDB) begin
                    n_fail++;
                    $display("FAIL load_new sel=%b dig=%h want 1011/DB",
                             sel, dig);
                end
            end
        end
    endtask

    task automatic test_lzb();
        int fb;
        logic [7:0] want [2][4];
        want[0] = '{8'hFC, 8'hB6, 8'h00, 8'h00};
        want[1] = '{8'hFC, 8'h00, 8'h00, 8'h00};
        lzb_en = 1'b1;
        dp_in = 4'd0;
        for (int p = 0; p < 2; p++) begin
            bcd_in = (p == 0) ? 16'h0050 : 16'h0000;
            load = 1'b1;
            step();
            load = 1'b0;
            fb = (m_n / FR + 1) * FR;
            while (m_n < fb + FR - 1) begin
                step();
                n_tests++;
                if ({sel, dig, frame_done} !==
                    {exp_sel(), exp_dig(), exp_fd()}) begin
                    n_fail++;
                    $display("FAIL lzb n=%0d got %b/%h/%b exp %b/%h/%b",
                             m_n, sel, dig, frame_done,
                             exp_sel(), exp_dig(), exp_fd());
                end
                if (m_n >= fb && m_n % CD == BC + 1) begin
                    n_tests++;
                    if (dig !== want[p][(m_n / CD) % 4] || sel === 4'hF) begin
                        n_fail++;
                        $display("FAIL lzb_fixed p=%0d n=%0d sel=%b dig=%h want %h",
                                 p, m_n, sel, dig, want[p][(m_n / CD) % 4]);
                    end
                end
            end
        end
    endtask

    task automatic test_invalid();
        int fb;
        logic [7:0] want [2][4];
        want[0] = '{8'hFC, 8'h02, 8'hFC, 8'hFC};
        want[1] = '{8'hFC, 8'h02, 8'h00, 8'h00};
        lzb_en = 1'b0;
        bcd_in = 16'h00B0;
        dp_in = 4'd0;
        load = 1'b1;
        step();
        load = 1'b0;
        fb = (m_n / FR + 1) * FR;
        while (m_n < fb + 2 * FR - 1) begin
            if (m_n == fb + FR - 1) lzb_en = 1'b1;
            step();
            n_tests++;
            if ({sel, dig, frame_done} !==
                {exp_sel(), exp_dig(), exp_fd()}) begin
                n_fail++;
                $display("FAIL invalid n=%0d got %b/%h/%b exp %b/%h/%b",
                         m_n, sel, dig, frame_done,
                         exp_sel(), exp_dig(), exp_fd());
            end
            if (m_n >= fb && m_n % CD == BC) begin
                n_tests++;
                if (dig !== want[int'(m_n >= fb + FR)][(m_n / CD) % 4]) begin
                    n_fail++;
                    $display("FAIL invalid_fixed n=%0d dig=%h want %h", m_n, dig,
                             want[int'(m_n >= fb + FR)][(m_n / CD) % 4]);
                end
            end
        end
        lzb_en = 1'b0;
    endtask

    task automatic test_boundary_load();
        int fb;
        while (m_n % FR != 10) step();
        bcd_in = 16'h1111;
        dp_in = 4'd0;
        load = 1'b1;
        step();
        load = 1'b0;
        while ((m_n + 1) % FR != 0) step();
        bcd_in = 16'h2222;
        load = 1'b1;
        step();
        load = 1'b0;
        fb = m_n;
        while (m_n < fb + 2 * FR - 1) begin
            step();
            n_tests++;
            if ({sel, dig, frame_done} !==
                {exp_sel(), exp_dig(), exp_fd()}) begin
                n_fail++;
                $display("FAIL bnd n=%0d got %b/%h/%b exp %b/%h/%b",
                         m_n, sel, dig, frame_done,
                         exp_sel(), exp_dig(), exp_fd());
            end
            if (m_n % CD == BC) begin
                n_tests++;
                if (dig !== ((m_n < fb + FR) ? 8'h60 : 8'hDA)) begin
                    n_fail++;
                    $display("FAIL bnd_fixed n=%0d dig=%h want %h", m_n, dig,
                             (m_n < fb + FR) ? 8'h60 : 8'hDA);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        while (m_n % FR != 5) step();
        bcd_in = 16'h9999;
        dp_in = 4'b1111;
        load = 1'b1;
        step();
        load = 1'b0;
        while (m_n % FR != 2 * CD + 4) step();
        rst = 1'b1;
        step();
        n_tests++;
        if ({sel, dig, frame_done} !== 13'b1111_0000_0000_0) begin
            n_fail++;
            $display("FAIL rst_mid sel=%b dig=%h fd=%b want 1111/00/0",
                     sel, dig, frame_done);
        end
        rst = 1'b0;
        for (int i = 0; i < 2 * FR + 4; i++) begin
            step();
            n_tests++;
            if ({sel, dig, frame_done} !==
                {exp_sel(), exp_dig(), exp_fd()}) begin
                n_fail++;
                $display("FAIL rst_run n=%0d got %b/%h/%b exp %b/%h/%b",
                         m_n, sel, dig, frame_done,
                         exp_sel(), exp_dig(), exp_fd());
            end
            if (m_n % CD >= BC) begin
                n_tests++;
                if (dig !== 8'hFC) begin
                    n_fail++;
                    $display("FAIL rst_zero n=%0d dig=%h want FC", m_n, dig);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] masks [4];
        masks = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F};
        for (int i = 0; i < 1200; i++) begin
            load = ($urandom_range(0, 15) == 0);
            bcd_in = 16'($urandom) & masks[$urandom_range(0, 3)];
            dp_in = 4'($urandom);
            if ($urandom_range(0, 31) == 0) lzb_en = ~lzb_en;
            rst = ($urandom_range(0, 499) == 0);
            step();
            n_tests++;
            if ({sel, dig, frame_done} !==
                {exp_sel(), exp_dig(), exp_fd()}) begin
                n_fail++;
                $display("FAIL random n=%0d got %b/%h/%b exp %b/%h/%b",
                         m_n, sel, dig, frame_done,
                         exp_sel(), exp_dig(), exp_fd());
            end
        end
        load = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_scan();
        test_load_midframe();
        test_lzb();
        test_invalid();
        test_boundary_load();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
